// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-stage valid/ready pipeline register with flush, start gating,
// bubble collapsing and an optional one-entry input skid buffer.
module pipe_reg_elastic #(
   parameter int DATA_W      = 32,
   parameter int CTRL_W      = 16,
   parameter int DEPTH       = 1,
   parameter int SKID        = 0,
   parameter int ZERO_BUBBLE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [2:0]        occupancy
);
   localparam int PW = DATA_W + CTRL_W;
   logic [DEPTH-1:0] v, adv, sv;
   logic [PW-1:0] p [DEPTH];
   logic [PW-1:0] sp [DEPTH];
   logic [PW-1:0] skid_p;
   logic skid_v, kill, acc;
   assign kill = flush | ~start;
   assign in_ready = reset & ~kill & ((SKID != 0) ? ~skid_v : adv[0]);
   assign acc = in_valid & in_ready;
   assign out_valid = v[DEPTH-1];
   assign {out_ctrl, out_data} = p[DEPTH-1];
   // adv chain flattened: a stage may load when downstream is ready or any later stage is empty
   always_comb begin
      sv[0] = skid_v | acc;
      sp[0] = skid_v ? skid_p : {in_ctrl, in_data};
      for (int i = 1; i < DEPTH; i++) begin
         sv[i] = v[i-1];
         sp[i] = p[i-1];
      end
      for (int i = 0; i < DEPTH; i++)
         adv[i] = out_ready | ~&(v | DEPTH'((1 << i) - 1));
   end
   always_comb begin
      occupancy = {2'b00, skid_v};
      for (int i = 0; i < DEPTH; i++)
         occupancy = occupancy + {2'b00, v[i]};
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v      <= '0;
         skid_v <= 1'b0;
         skid_p <= '0;
         for (int i = 0; i < DEPTH; i++) p[i] <= '0;
      end else if (kill) begin
         v      <= '0;
         skid_v <= 1'b0;
         if (ZERO_BUBBLE != 0) begin
            skid_p <= '0;
            for (int i = 0; i < DEPTH; i++) p[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (adv[i]) begin
               v[i] <= sv[i];
               p[i] <= (ZERO_BUBBLE != 0 && !sv[i]) ? '0 : sp[i];
            end
         // the skid only fills when stage 0 is blocked, and drains before new input is taken
         if (SKID != 0 && skid_v && adv[0])
            skid_v <= 1'b0;
         else if (SKID != 0 && acc && !adv[0]) begin
            skid_v <= 1'b1;
            skid_p <= {in_ctrl, in_data};
         end
      end
   end
endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb_pipe_reg_elastic: four configurations driven in parallel, checked by a vector table,
// per-instance scoreboards and hand-written corner-case sequences.
module tb_pipe_reg_elastic;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic [15:0] in_ctrl = '0;
   logic [3:0] rdy, ov;
   logic [3:0][31:0] od;
   logic [3:0][15:0] oc;
   logic [3:0][2:0] occ;
   int vecs = 0, errs = 0;
   logic [47:0] q [4][$];
   int cnt [4];
   bit pend [4];
   logic [47:0] hold [4];

   typedef struct {
      logic iv;
      logic [31:0] d;
      logic ordy;
      logic e_ir;
      logic e_ov;
      logic [31:0] e_od;
      logic [2:0] e_occ;
   } vec_t;

   always #5 clk = ~clk;

   function automatic int dep(int g);
      return g == 0 ? 2 : g == 1 ? 3 : g == 2 ? 1 : 4;
   endfunction
   function automatic int skd(int g);
      return g >= 2 ? 1 : 0;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      pipe_reg_elastic #(
         .DATA_W(32), .CTRL_W(16), .DEPTH(dep(g)), .SKID(skd(g)), .ZERO_BUBBLE(g == 2 ? 0 : 1)
      ) u (
         .clk(clk), .reset(reset), .start(start), .flush(flush),
         .in_valid(in_valid), .in_ready(rdy[g]), .in_data(in_data), .in_ctrl(in_ctrl),
         .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]), .out_ctrl(oc[g]),
         .occupancy(occ[g])
      );
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic vld, input logic [31:0] d);
      in_valid = vld;
      in_data  = d;
      in_ctrl  = {8'hC0, d[7:0]};
   endtask

   task automatic drain();
      put(1'b0, 32'h0);
      out_ready = 1'b1;
      for (int k = 0; k < 20 && occ != '0; k++) cyc();
      chk("drain_occ", occ, 0);
   endtask

   task automatic fill();
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         put(1'b1, k == 1 ? 32'h55 : 32'hB0 + k);
         cyc();
      end
   endtask

   // one beat into an empty pipe; each instance must present it exactly DEPTH cycles later
   task automatic lat(input logic [31:0] d);
      int seen [4];
      for (int g = 0; g < 4; g++) seen[g] = -1;
      out_ready = 1'b1;
      put(1'b1, d);
      @(negedge clk);
      chk("lat_accept", rdy, 4'hF);
      cyc();
      put(1'b0, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         for (int g = 0; g < 4; g++)
            if (ov[g] && seen[g] < 0) seen[g] = k;
         cyc();
      end
      for (int g = 0; g < 4; g++) chk($sformatf("latency_u%0d", g), 64'(seen[g]), 64'(dep(g)));
   endtask

   // scoreboard / protocol monitor, sampled on the falling edge
   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
         if (!reset) begin
            chk($sformatf("reset_u%0d", g), {rdy[g], ov[g], od[g], oc[g], occ[g]}, 0);
            q[g].delete();
            cnt[g]  = 0;
            pend[g] = 1'b0;
         end else begin
            chk($sformatf("occ_u%0d", g), occ[g], 64'(cnt[g]));
            if (pend[g]) chk($sformatf("stall_hold_u%0d", g), {ov[g], oc[g], od[g]}, {1'b1, hold[g]});
            if (g != 2 && !ov[g]) chk($sformatf("bubble_zero_u%0d", g), {oc[g], od[g]}, 0);
            if (ov[g] && out_ready) begin
               chk($sformatf("sb_expected_u%0d", g), ov[g], q[g].size() != 0);
               if (q[g].size() != 0) chk($sformatf("sb_data_u%0d", g), {oc[g], od[g]}, q[g].pop_front());
            end
            if (flush || !start) begin
               chk($sformatf("kill_ready_u%0d", g), rdy[g], 0);
               q[g].delete();
               cnt[g]  = 0;
               pend[g] = 1'b0;
            end else begin
               if (in_valid && rdy[g]) begin
                  q[g].push_back({in_ctrl, in_data});
                  cnt[g]++;
               end
               if (ov[g] && out_ready) cnt[g]--;
               pend[g] = ov[g] && !out_ready;
               hold[g] = {oc[g], od[g]};
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tv [14];
      tv = '{
         '{1'b1, 32'hA0, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0},
         '{1'b1, 32'hA1, 1'b1, 1'b1, 1'b0, 32'h00, 3'd1},
         '{1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA0, 3'd2},
         '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA1, 3'd2},
         '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA2, 3'd2},
         '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA3, 3'd1},
         '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0},
         '{1'b1, 32'hB0, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0},
         '{1'b1, 32'hB1, 1'b0, 1'b1, 1'b0, 32'h00, 3'd1},
         '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB0, 3'd2},
         '{1'b1, 32'hB2, 1'b1, 1'b1, 1'b1, 32'hB0, 3'd2},
         '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hB1, 3'd2},
         '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hB2, 3'd1},
         '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0}
      };
      #1 reset = 1'b0;
      start = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;

      // DEPTH=2 instance against the vector table
      for (int r = 0; r < 14; r++) begin
         put(tv[r].iv, tv[r].d);
         out_ready = tv[r].ordy;
         @(negedge clk);
         chk($sformatf("table_row%0d", r), {rdy[0], ov[0], od[0], occ[0]},
             {tv[r].e_ir, tv[r].e_ov, tv[r].e_od, tv[r].e_occ});
         cyc();
      end
      drain();

      // backpressure: every instance fills to DEPTH+SKID and stops accepting
      fill();
      put(1'b1, 32'hBF);
      @(negedge clk);
      for (int g = 0; g < 4; g++)
         chk($sformatf("full_u%0d", g), {occ[g], rdy[g], ov[g]}, {3'(dep(g) + skd(g)), 1'b0, 1'b1});
      chk("skid_parked_u2", {od[2], occ[2]}, {32'hB0, 3'd2});
      cyc();
      drain();

      // flush with a full pipe and a coincident beat
      fill();
      flush = 1'b1;
      put(1'b1, 32'h99);
      @(negedge clk);
      chk("flush_ready", rdy, 0);
      cyc();
      flush = 1'b0;
      put(1'b0, 32'h0);
      chk("flush_state", {ov, occ, od[0], od[1], od[3]}, 0);
      out_ready = 1'b1;
      repeat (8) cyc();

      // start=0 for two cycles mid-stream
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         put(1'b1, 32'hC0 + k);
         cyc();
      end
      start = 1'b0;
      put(1'b1, 32'hEE);
      cyc();
      @(negedge clk);
      chk("start_bubble", {ov, oc[0], oc[1], oc[3], occ}, 0);
      cyc();
      start = 1'b1;
      put(1'b0, 32'h0);
      cyc();
      lat(32'hC8);

      // asynchronous reset between edges with beats held
      fill();
      #2 reset = 1'b0;
      put(1'b0, 32'h0);
      #1 chk("async_reset", {ov, occ, rdy, od, oc}, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      out_ready = 1'b1;
      cyc();
      lat(32'hD0);

      // random traffic with occasional flush and start gaps
      for (int k = 0; k < 400; k++) begin
         put($urandom_range(0, 3) != 0, $urandom);
         in_ctrl   = 16'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 39) == 0;
         start     = $urandom_range(0, 49) != 0;
         cyc();
      end
      flush = 1'b0;
      start = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised, multi-stage pipeline register for inter-stage control and data bundles, with valid/ready backpressure, synchronous flush, global start gating and an optional input skid buffer.
- Replaces fixed single-stage stage registers: one instance carries a decode-to-execute, execute-to-memory, or AES-datapath bundle across DEPTH register stages.
- Stalls propagate without data loss, and bubbles are collapsed.

Parameters:
- DATA_W, 32, width of data payload (operands, immediates, PC, AES words).
- CTRL_W, 16, width of control payload (write-enables, ALU op, AES mode/key-size bits).
- DEPTH, 1, number of register stages; legal range 1..4.
- SKID, 0, 1 = registered in_ready via one-entry input skid buffer; 0 = combinational in_ready.
- ZERO_BUBBLE, 1, 1 = data/ctrl outputs of an invalid stage forced to 0; 0 = payload held, only valid cleared.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  global enable; 0 clears every stage (bubble insertion) each cycle.
- flush  in  1  synchronous kill of all in-flight beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block accepts beat this cycle.
- in_data  in  DATA_W  data payload.
- in_ctrl  in  CTRL_W  control payload.
- out_valid  out  1  last stage holds valid beat.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DATA_W  last-stage data.
- out_ctrl  out  CTRL_W  last-stage control.
- occupancy  out  3  count of valid beats held (stages + skid), 0..DEPTH+SKID.

Behaviour:
- Reset (reset=0, asynchronous):
  - all stage valids and the skid valid = 0; all payload registers = 0.
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - in_ready=0 while reset is asserted.
- Priority: reset > (flush or !start) > normal operation.
- Flush / start=0:
  - at the next edge every valid (stages + skid) = 0; payloads = 0 when ZERO_BUBBLE=1.
  - in_ready=0 combinationally in that cycle; a coincident in_valid beat is dropped, never stored.
- Stage i holds valid v[i] and payload p[i]; stage DEPTH-1 drives the outputs.
  - Stage advance enable: adv[i] = !v[i] | adv[i+1], with adv[DEPTH] = out_ready.
  - On adv[i]: v[i] <= v[i-1] and p[i] <= p[i-1], with stage 0 fed from the input/skid.
  - When !adv[i]: stage holds.
  - Empty stages always fill, so bubbles collapse.
- Handshake:
  - out transfer when out_valid & out_ready; in transfer when in_valid & in_ready.
  - out_valid never drops and out_data/out_ctrl never change while out_valid=1 and out_ready=0.
- SKID=0:
  - in_ready = adv[0] & start & !flush & reset.
- SKID=1:
  - in_ready = !skid_v & start & !flush (registered term only).
  - If the beat is accepted while adv[0]=0, it is written to the skid register (skid_v=1).
  - While skid_v=1, stage 0 loads from the skid on adv[0]; the input is not accepted, so order is preserved.
  - Skid drain and a new accept cannot occur in the same cycle.
- Latency: a beat accepted at edge t into an empty pipe with out_ready=1 is presented on out_valid after DEPTH cycles. A beat parked in the skid adds 1 cycle.
- Throughput: 1 beat/cycle sustained with out_ready=1, for all DEPTH and SKID.
- ZERO_BUBBLE=1: out_data/out_ctrl = 0 whenever out_valid=0.
- occupancy:
  - registered, equal to popcount of valid bits after each edge.
  - +1 per in transfer, −1 per out transfer; net 0 on simultaneous transfers.
  - 0 after flush/start=0.
- Reset mid-stream: all content lost immediately; the first beat after release is accepted no earlier than the first edge with reset=1.

Test Plan:
- DEPTH=2, SKID=0, out_ready=1: send beats data 0xA0..0xA3 on consecutive cycles → out_valid on cycles 2..5 with data A0,A1,A2,A3 in order; occupancy steady at 2.
- DEPTH=3: hold out_ready=0 while streaming → after 3 accepts, in_ready=0 and occupancy=3; then out_ready=1 → outputs released in order, no duplicates or drops.
- SKID=1, DEPTH=1: out_ready low at accept of beat 0x55 with stage full → beat parked (occupancy=2, in_ready=0 next cycle); release out_ready → stage beat out, then 0x55 one cycle later.
- Assert flush with pipe full (DEPTH=4) and in_valid=1 (data 0x99) → next cycle out_valid=0, out_data=0, occupancy=0; 0x99 never appears at the output.
- Drive start=0 for 2 cycles mid-stream → bubbles only (out_ctrl=0); resume start=1 → new beats flow with latency DEPTH.
- Pulse reset low asynchronously between edges with valid beats held → outputs zero immediately; after release, the first beat completes with latency DEPTH.
